mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
//
// PURPOSE
//   Upstream driver for the 4:1 single-bit mux: walks the select lines through
//   channels 0..3 and waits SETTLE_CYCLES after each select change. It then samples
//   mux output y and assembles the four samples into one 4-bit frame. The frame is
//   handed to the consumer over a valid/ready handshake. One scan runs per start request.
//
// PARAMETERS
//   SETTLE_CYCLES  2   cycles held per channel before sampling y; legal range 1..15
//   CNT_W          4   width of settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES
//
// PORTS
//   clk          in   1  single clock; all logic on rising edge
//   rst          in   1  synchronous, active-high reset
//   start        in   1  scan request, sampled in IDLE (and on HOLD handshake edge)
//   y            in   1  output of the 4:1 mux
//   sel0         out  1  mux select LSB; channel = {sel1,sel0}
//   sel1         out  1  mux select MSB
//   busy         out  1  high in every state except IDLE
//   frame        out  4  captured samples; frame[n] = y while channel n selected
//   frame_valid  out  1  frame available; high only in HOLD
//   frame_ready  in   1  consumer accepts frame when frame_valid && frame_ready
//   ch_mask      in   4  (SCAN_MASK_EN only) 1 = scan channel n
//
// BEHAVIOUR
//   - Reset values: sel0=0, sel1=0, busy=0, frame=4'b0000, frame_valid=0; state=IDLE.
//   - States: IDLE, SETTLE, SAMPLE, HOLD.
//   - IDLE: select outputs 00. On start=1, go to SETTLE with ch=0 and cnt=0.
//     The internal shadow register clears to 0 on this transition.
//   - SETTLE: drive {sel1,sel0}=ch. cnt increments each cycle. On cnt==SETTLE_CYCLES-1, go to SAMPLE.
//   - SAMPLE: shadow[ch]<=y. If ch==3, set frame<=shadow with bit 3 = y and go to HOLD.
//     Otherwise ch<=ch+1, cnt<=0, go to SETTLE. Channel index never wraps mid-scan.
//   - Each channel occupies SETTLE_CYCLES+1 cycles. The edge that accepts start is edge k.
//     frame_valid rises at edge k+4*(SETTLE_CYCLES+1): edge k+12 for the default.
//   - HOLD: frame_valid=1. frame and selects are stable until the handshake; select stays 11.
//     On the handshake edge: start=1 goes directly to SETTLE, ch=0 (back-to-back, no IDLE bubble).
//     Otherwise go to IDLE with frame_valid=0. frame keeps its last value in IDLE.
//   - start is ignored in SETTLE and SAMPLE. start and y are treated as synchronous to clk.
//   - Reset mid-scan or in HOLD: return to IDLE on the next edge. The partial frame is discarded.
//     Reset values apply.
//   - frame_ready while frame_valid=0 has no effect.
//
// CONFIGURATION
//   SCAN_MASK_EN defined:
//     - ch_mask port exists and is latched on the start edge.
//     - Unmasked channels are skipped with zero cycles spent; their frame bit is 0.
//     - ch advances to the next set mask bit.
//     - Latency = popcount(mask)*(SETTLE_CYCLES+1) cycles.
//     - mask=4'b0000: enter HOLD one edge after start, with frame=0.
//   SCAN_MASK_EN undefined:
//     - No ch_mask port. All four channels are always scanned; fixed latency as above.
//
// STRUCTURE
//   - Package mux_scan_pkg holds:
//     - scan_state_t enum (IDLE, SETTLE, SAMPLE, HOLD)
//     - NUM_CH=4
//     - CH_W=2
//     - helper function next_ch(cur, mask) returning next enabled channel or NUM_CH
//   - One sub-module, mux_settle_timer: a CNT_W-bit counter with clear/enable inputs.
//     Its done flag = (cnt==SETTLE_CYCLES-1). The FSM, channel index and frame registers
//     stay in the top level.
//
// TESTING
//   1. Reset: assert rst 2 cycles -> sel=00, busy=0, frame=0000, frame_valid=0.
//   2. Basic scan: mux model i0..i3=1,0,1,1, pulse start, ready=1
//      -> frame_valid at edge k+12, frame=4'b1101, then IDLE.
//   3. Backpressure: i0..i3=0,1,1,0, ready=0 for 5 cycles after valid -> frame=4'b0110 held.
//      Selects remain 11 and valid stays high until ready=1 accepts.
//   4. Back-to-back: start=1 on the handshake edge with inputs changed to 0,0,0,1
//      -> no IDLE cycle; second frame=4'b1000 at +12.
//   5. Reset mid-scan: rst during channel 2 SETTLE -> next edge: IDLE, sel=00, no frame_valid.
//      A new start produces a correct full frame.
//   6. SCAN_MASK_EN: mask=4'b1010, inputs all 1 -> only channels 1,3 selected;
//      frame=4'b1010 at k+6. mask=0000 -> frame_valid at k+1, frame=0000.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types, constants and channel-walk helper for the 4:1 mux scan sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // Channel index value meaning "no further enabled channel".
    localparam logic [CH_W:0] CH_END = (CH_W+1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } scan_state_t;

    // Lowest enabled channel at or above cur; CH_END when none remain.
    function automatic logic [CH_W:0] next_ch(input logic [CH_W:0]   cur,
                                              input logic [NUM_CH-1:0] mask);
        logic [CH_W:0] res;
        res = CH_END;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (((CH_W+1)'(i) >= cur) && mask[i]) begin
                res = (CH_W+1)'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_settle_timer.sv
// Settle counter: counts cycles spent on one mux channel; done when cnt == SETTLE_CYCLES-1.
// Latency: done is a registered-count compare, valid the cycle the count reaches the limit.
// Backpressure: none; clr has priority over en.
module mux_settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] DONE_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == DONE_VAL);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks a 4:1 mux through its channels, samples y after settling, hands a 4-bit frame out.
// Latency: start edge k -> frame_valid after edge k + enabled_channels*(SETTLE_CYCLES+1).
// Backpressure: frame, selects and frame_valid hold in HOLD until frame_valid && frame_ready.
// Optional macro SCAN_MASK_EN adds ch_mask to skip channels; default build scans all four.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y,
    output logic              sel0,
    output logic              sel1,
    output logic              busy,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready
`ifdef SCAN_MASK_EN
    ,
    input  logic [NUM_CH-1:0] ch_mask
`endif
);

    scan_state_t       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] start_mask;
    logic [NUM_CH-1:0] sampled;
    logic [CH_W:0]     first_ch;
    logic [CH_W:0]     after_ch;
    logic [CH_W-1:0]   sel;
    logic              settle_done;
    logic              tmr_clr;
    logic              tmr_en;

`ifdef SCAN_MASK_EN
    assign start_mask = ch_mask;
`else
    assign start_mask = '1;
`endif

    // Counter runs only while settling and restarts from zero on every channel.
    assign tmr_en  = (state_q == SETTLE);
    assign tmr_clr = (state_q != SETTLE);

    mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (settle_done)
    );

    // Channel bookkeeping: shadow with the current sample merged in, and the walk order.
    always_comb begin
        sampled          = shadow_q;
        sampled[ch_q]    = y & mask_q[ch_q];
        first_ch         = next_ch('0, start_mask);
        after_ch         = next_ch({1'b0, ch_q} + (CH_W+1)'(1), mask_q);
    end

    // Next-state logic; a scan launch is shared by IDLE and the HOLD handshake edge.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        mask_d   = mask_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = '0;
                    mask_d   = start_mask;
                    if (first_ch == CH_END) begin
                        // Empty mask: one SAMPLE pass with nothing enabled yields frame 0.
                        ch_d    = '0;
                        state_d = SAMPLE;
                    end else begin
                        ch_d    = first_ch[CH_W-1:0];
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_d = sampled;
                if (after_ch == CH_END) begin
                    frame_d = sampled;
                    state_d = HOLD;
                end else begin
                    ch_d    = after_ch[CH_W-1:0];
                    state_d = SETTLE;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    if (start) begin
                        shadow_d = '0;
                        mask_d   = start_mask;
                        if (first_ch == CH_END) begin
                            ch_d    = '0;
                            state_d = SAMPLE;
                        end else begin
                            ch_d    = first_ch[CH_W-1:0];
                            state_d = SETTLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, channel and frame registers; reset discards any partial scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            mask_q   <= '1;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            mask_q   <= mask_d;
        end
    end

    // Select drive: 00 when idle, parked at 11 while a frame waits, else the live channel.
    always_comb begin
        sel = ch_q;
        if (state_q == IDLE) begin
            sel = '0;
        end else if (state_q == HOLD) begin
            sel = '1;
        end
    end

    assign sel0        = sel[0];
    assign sel1        = sel[1];
    assign busy        = (state_q != IDLE);
    assign frame_valid = (state_q == HOLD);
    assign frame       = frame_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 4:1 mux on y.
// Latency: checks land #1 after each rising edge.
// Backpressure: frame_ready driven per scenario.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       y;
    logic       sel0, sel1, busy, frame_valid;
    logic       frame_ready = 1'b0;
    logic [3:0] frame;
    logic [3:0] in_v = 4'b0000;
`ifdef SCAN_MASK_EN
    logic [3:0] ch_mask = 4'b1111;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Mux model: channel = {sel1,sel0}.
    assign y = in_v[{sel1, sel0}];

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .y           (y),
        .sel0        (sel0),
        .sel1        (sel1),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
`ifdef SCAN_MASK_EN
        ,
        .ch_mask     (ch_mask)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({sel1, sel0} !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", {sel1, sel0}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame !== 4'b0000) begin errors++; $display("FAIL reset_frame got=%b exp=0000", frame); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_scan();
        logic [1:0] exp_ch;
        in_v = 4'b1101;
        frame_ready = 1'b1;
        start = 1'b1;
        tick();                       // edge k
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int j = 0; j < 12; j++) begin
            exp_ch = 2'(j / 3);
            checks++; if ({sel1, sel0} !== exp_ch) begin errors++; $display("FAIL basic_sel j=%0d got=%b exp=%b", j, {sel1, sel0}, exp_ch); end
            checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid j=%0d got=%b exp=0", j, frame_valid); end
            if (j < 11) tick();
        end
        tick();                       // edge k+12
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", frame_valid); end
        checks++; if (frame !== 4'b1101) begin errors++; $display("FAIL basic_frame got=%b exp=1101", frame); end
        checks++; if ({sel1, sel0} !== 2'b11) begin errors++; $display("FAIL basic_hold_sel got=%b exp=11", {sel1, sel0}); end
        tick();                       // handshake edge
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid got=%b exp=0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_after_busy got=%b exp=0", busy); end
        checks++; if (frame !== 4'b1101) begin errors++; $display("FAIL basic_frame_kept got=%b exp=1101", frame); end
        checks++; if ({sel1, sel0} !== 2'b00) begin errors++; $display("FAIL basic_idle_sel got=%b exp=00", {sel1, sel0}); end
    endtask

    task automatic test_backpressure();
        in_v = 4'b0110;
        frame_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", frame_valid); end
        in_v = 4'b1111;               // inputs moving must not disturb a held frame
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", j, frame_valid); end
            checks++; if (frame !== 4'b0110) begin errors++; $display("FAIL bp_hold_frame c=%0d got=%b exp=0110", j, frame); end
            checks++; if ({sel1, sel0} !== 2'b11) begin errors++; $display("FAIL bp_hold_sel c=%0d got=%b exp=11", j, {sel1, sel0}); end
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        in_v = 4'b1101;
        frame_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) tick();
        checks++; if (frame !== 4'b1101) begin errors++; $display("FAIL b2b_first_frame got=%b exp=1101", frame); end
        in_v = 4'b1000;               // i0..i3 = 0,0,0,1
        start = 1'b1;
        frame_ready = 1'b1;
        tick();                       // handshake edge doubles as start edge
        start = 1'b0;
        frame_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle got=%b exp=1", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", frame_valid); end
        checks++; if ({sel1, sel0} !== 2'b00) begin errors++; $display("FAIL b2b_sel got=%b exp=00", {sel1, sel0}); end
        for (int j = 0; j < 11; j++) tick();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got=%b exp=0", frame_valid); end
        tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", frame_valid); end
        checks++; if (frame !== 4'b1000) begin errors++; $display("FAIL b2b_frame got=%b exp=1000", frame); end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        in_v = 4'b1111;
        frame_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 6; j++) tick();  // first SETTLE cycle of channel 2
        checks++; if ({sel1, sel0} !== 2'b10) begin errors++; $display("FAIL mid_sel got=%b exp=10", {sel1, sel0}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if ({sel1, sel0} !== 2'b00) begin errors++; $display("FAIL mid_sel_rst got=%b exp=00", {sel1, sel0}); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", frame_valid); end
        checks++; if (frame !== 4'b0000) begin errors++; $display("FAIL mid_frame got=%b exp=0000", frame); end
        for (int j = 0; j < 14; j++) begin
            tick();
            checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_stray_valid c=%0d got=%b exp=0", j, frame_valid); end
        end
        in_v = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mid_rescan_valid got=%b exp=1", frame_valid); end
        checks++; if (frame !== 4'b0101) begin errors++; $display("FAIL mid_rescan_frame got=%b exp=0101", frame); end
        tick();
    endtask

`ifdef SCAN_MASK_EN
    task automatic test_mask();
        in_v = 4'b1111;
        ch_mask = 4'b1010;
        frame_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_mask = 4'b1111;            // latched on the start edge only
        checks++; if ({sel1, sel0} !== 2'b01) begin errors++; $display("FAIL mask_sel_a got=%b exp=01", {sel1, sel0}); end
        tick(); tick(); tick();
        checks++; if ({sel1, sel0} !== 2'b11) begin errors++; $display("FAIL mask_sel_b got=%b exp=11", {sel1, sel0}); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mask_early got=%b exp=0", frame_valid); end
        tick(); tick(); tick();       // edge k+6
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mask_valid got=%b exp=1", frame_valid); end
        checks++; if (frame !== 4'b1010) begin errors++; $display("FAIL mask_frame got=%b exp=1010", frame); end
        frame_ready = 1'b1;
        tick();
        ch_mask = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mask0_early got=%b exp=0", frame_valid); end
        tick();                       // edge k+1
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mask0_valid got=%b exp=1", frame_valid); end
        checks++; if (frame !== 4'b0000) begin errors++; $display("FAIL mask0_frame got=%b exp=0000", frame); end
        tick();
        ch_mask = 4'b1111;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef SCAN_MASK_EN
        test_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
